calc_seq_engine: RTL

Sequential, handshaked calculator engine that accepts one signed operation request per transaction and returns a result with a status code. It serves the request side of the calculator operand/result interface: a request is accepted, executed over one or more cycles, and returned through a ready/valid response port. Power is computed iteratively, one multiply per cycle. Every result carries overflow, divide-by-zero and invalid-request status.

---
 rtl/calc_seq_engine.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/calc_seq_engine.sv
// calc_seq_engine
// Sequential signed calculator with a ready/valid request and response port.
// The engine accepts one request in IDLE, executes it in CALC and presents
// the result in DONE until the consumer takes it. Power is iterated with one
// multiply per cycle and stops at the first overflowing product.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   request valid
//   in_ready   engine can accept a request (state == IDLE)
//   a, b       signed operands (b is the exponent for power)
//   operand    opcode: 0 add, 1 sub, 2 mul, 3 div, 4 pow, 5..7 invalid
//   out_valid  response valid (state == DONE)
//   out_ready  consumer accepts the response
//   result     signed result, low nb bits
//   status     0 ok, 1 overflow, 2 divide-by-zero, 3 invalid
//   busy       state is not IDLE
module calc_seq_engine #(
  parameter int nb = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [nb-1:0] a,
  input  logic [nb-1:0] b,
  input  logic [2:0]    operand,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [nb-1:0] result,
  output logic [1:0]    status,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_POW = 3'd4;

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_OVF = 2'd1;
  localparam logic [1:0] ST_DBZ = 2'd2;
  localparam logic [1:0] ST_INV = 2'd3;

  localparam logic [nb-1:0] ZERO = {nb{1'b0}};
  localparam logic [nb-1:0] ONE  = {{(nb-1){1'b0}}, 1'b1};
  localparam logic [nb-1:0] NEG1 = {nb{1'b1}};
  localparam logic [nb-1:0] MINV = {1'b1, {(nb-1){1'b0}}};

  state_t        state_r, state_s;
  logic [nb-1:0] a_r, b_r, acc_r, cnt_r;
  logic [2:0]    op_r;
  logic          first_r, fin_r;

  logic [nb-1:0] acc_s, cnt_s, res_s;
  logic [1:0]    sts_s;
  logic          first_s, fin_s;

  // Shared datapath: adder, subtractor, one multiplier and a guarded divider.
  logic [nb:0]          sum_s, dif_s;
  logic                 sum_ovf_s, dif_ovf_s, mul_ovf_s;
  logic [nb-1:0]        mx_s, dv_s, quot_s;
  logic signed [2*nb-1:0] px_s, py_s, prod_s;

  assign sum_s     = {a_r[nb-1], a_r} + {b_r[nb-1], b_r};
  assign dif_s     = {a_r[nb-1], a_r} - {b_r[nb-1], b_r};
  assign sum_ovf_s = sum_s[nb] ^ sum_s[nb-1];
  assign dif_ovf_s = dif_s[nb] ^ dif_s[nb-1];

  // Plain mul multiplies a*b; power steps multiply the accumulator by a.
  assign mx_s   = (op_r == OP_MUL) ? b_r : acc_r;
  assign px_s   = $signed({{nb{a_r[nb-1]}}, a_r});
  assign py_s   = $signed({{nb{mx_s[nb-1]}}, mx_s});
  assign prod_s = px_s * py_s;
  // The product fits in nb bits only if the top nb+1 bits are all equal.
  assign mul_ovf_s = (prod_s[2*nb-1:nb-1] != {(nb+1){prod_s[nb-1]}});

  // Division by zero and MIN/-1 are reported separately; divide by one there
  // so the divider never sees an undefined case (MIN/1 yields MIN directly).
  assign dv_s   = ((b_r == ZERO) || ((a_r == MINV) && (b_r == NEG1))) ? ONE : b_r;
  assign quot_s = $signed(a_r) / $signed(dv_s);

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-cycle datapath control.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    first_s = first_r;
    fin_s   = fin_r;
    res_s   = result;
    sts_s   = status;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (fin_r) begin
          // The final value was registered on the previous edge.
          state_s = DONE;
        end else if (first_r) begin
          first_s = 1'b0;
          fin_s   = 1'b1;
          sts_s   = ST_OK;
          case (op_r)
            OP_ADD: begin
              res_s = sum_s[nb-1:0];
              sts_s = sum_ovf_s ? ST_OVF : ST_OK;
            end
            OP_SUB: begin
              res_s = dif_s[nb-1:0];
              sts_s = dif_ovf_s ? ST_OVF : ST_OK;
            end
            OP_MUL: begin
              res_s = prod_s[nb-1:0];
              sts_s = mul_ovf_s ? ST_OVF : ST_OK;
            end
            OP_DIV: begin
              if (b_r == ZERO) begin
                res_s = ZERO;
                sts_s = ST_DBZ;
              end else if ((a_r == MINV) && (b_r == NEG1)) begin
                res_s = MINV;
                sts_s = ST_OVF;
              end else begin
                res_s = quot_s;
              end
            end
            OP_POW: begin
              if (b_r[nb-1]) begin
                res_s = ZERO;
                sts_s = ST_INV;
              end else if (b_r == ZERO) begin
                res_s = ONE;
              end else if (a_r == ZERO) begin
                res_s = ZERO;
              end else if (a_r == ONE) begin
                res_s = ONE;
              end else if (a_r == NEG1) begin
                res_s = b_r[0] ? NEG1 : ONE;
              end else if (b_r == ONE) begin
                res_s = a_r;
              end else begin
                // General case: iterate, first step loads the accumulator.
                acc_s = a_r;
                cnt_s = b_r - ONE;
                fin_s = 1'b0;
              end
            end
            default: begin
              res_s = ZERO;
              sts_s = ST_INV;
            end
          endcase
        end else begin
          // Power iteration step.
          acc_s = prod_s[nb-1:0];
          cnt_s = cnt_r - ONE;
          if (mul_ovf_s) begin
            fin_s = 1'b1;
            res_s = prod_s[nb-1:0];
            sts_s = ST_OVF;
          end else if (cnt_r == ONE) begin
            fin_s = 1'b1;
            res_s = prod_s[nb-1:0];
            sts_s = ST_OK;
          end else begin
            fin_s = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Request latch, iteration registers and registered result/status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= ZERO;
      b_r     <= ZERO;
      op_r    <= 3'd0;
      acc_r   <= ZERO;
      cnt_r   <= ZERO;
      first_r <= 1'b0;
      fin_r   <= 1'b0;
      result  <= ZERO;
      status  <= ST_OK;
    end else if ((state_r == IDLE) && in_valid) begin
      a_r     <= a;
      b_r     <= b;
      op_r    <= operand;
      first_r <= 1'b1;
      fin_r   <= 1'b0;
    end else begin
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      first_r <= first_s;
      fin_r   <= fin_s;
      result  <= res_s;
      status  <= sts_s;
    end
  end

endmodule
